// File: rtl/qspi_mem_responder.sv
// QSPI memory target backed by on-chip RAM; the SPI pins are oversampled on clk.
// Optional QSPI_RESP_WRITE_EN: decode command 0x02 as a write (PSRAM); otherwise read-only (flash).
module qspi_mem_responder #(
    parameter int ADDR_BITS    = 12,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk_i,
    input  logic       spi_cs_n_i,
    input  logic [3:0] spi_data_i,
    output logic [3:0] spi_data_o,
    output logic [3:0] spi_data_oe
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        RDATA  = 3'd4,
        WDATA  = 3'd5,
        IGNORE = 3'd6
    } state_t;

    logic [2:0]           sclk_sync_r;
    logic [1:0]           cs_sync_r;
    logic [3:0]           data_meta_r, data_sync_r;
    logic                 rise_s, fall_s, cs_n_s;
    logic [3:0]           data_s;

    state_t               state_r, state_nxt_s;
    logic [7:0]           cnt_r, cnt_nxt_s;
    logic [ADDR_BITS-1:0] addr_r, addr_nxt_s, addr_shift_s, addr_inc_s, mem_addr_s;
    logic [3:0]           cmd_hi_r, cmd_hi_nxt_s;
    logic                 rd_r, rd_nxt_s;
    logic                 half_r, half_nxt_s;
    logic [3:0]           dout_r, dout_nxt_s;
    logic                 oe_r, oe_nxt_s;
    logic                 armed_r;
    logic                 mem_re_s;
    logic [7:0]           rd_data_r;
    logic [7:0]           mem_r [DEPTH] = '{default: 8'h00};
`ifdef QSPI_RESP_WRITE_EN
    logic [3:0]           wr_hi_r, wr_hi_nxt_s;
    logic                 mem_we_s;
`endif

    // Two-stage synchronisers, plus a third spi_clk stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 2'b00;
            data_meta_r <= 4'h0;
            data_sync_r <= 4'h0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], spi_clk_i};
            cs_sync_r   <= {cs_sync_r[0], spi_cs_n_i};
            data_meta_r <= spi_data_i;
            data_sync_r <= data_meta_r;
        end
    end

    assign rise_s       = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign fall_s       = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_n_s       = cs_sync_r[1];
    assign data_s       = data_sync_r;
    assign addr_shift_s = ADDR_BITS'({addr_r, data_s});
    assign addr_inc_s   = addr_r + ADDR_BITS'(1);

    // Next-state, address/counter and output decode; CS high overrides any clock edge
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        addr_nxt_s   = addr_r;
        cmd_hi_nxt_s = cmd_hi_r;
        rd_nxt_s     = rd_r;
        half_nxt_s   = half_r;
        dout_nxt_s   = dout_r;
        oe_nxt_s     = oe_r;
        mem_re_s     = 1'b0;
        mem_addr_s   = addr_r;
`ifdef QSPI_RESP_WRITE_EN
        wr_hi_nxt_s  = wr_hi_r;
        mem_we_s     = 1'b0;
`endif
        if (cs_n_s) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
            half_nxt_s  = 1'b0;
            dout_nxt_s  = 4'h0;
            oe_nxt_s    = 1'b0;
        end else if (rise_s) begin
            case (state_r)
                IDLE: begin
                    // An unarmed block (reset released with CS low) must not start a command
                    if (armed_r) begin
                        cmd_hi_nxt_s = data_s;
                        state_nxt_s  = CMD;
                    end else begin
                        state_nxt_s  = IGNORE;
                    end
                end
                CMD: begin
                    case ({cmd_hi_r, data_s})
                        8'h0B: begin
                            rd_nxt_s    = 1'b1;
                            cnt_nxt_s   = 8'd0;
                            state_nxt_s = ADDR;
                        end
`ifdef QSPI_RESP_WRITE_EN
                        8'h02: begin
                            rd_nxt_s    = 1'b0;
                            cnt_nxt_s   = 8'd0;
                            state_nxt_s = ADDR;
                        end
`endif
                        default: state_nxt_s = IGNORE;
                    endcase
                end
                ADDR: begin
                    addr_nxt_s = addr_shift_s;
                    if (cnt_r != 8'd5) begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_nxt_s = 8'd0;
                        if (!rd_r) begin
`ifdef QSPI_RESP_WRITE_EN
                            half_nxt_s  = 1'b0;
                            state_nxt_s = WDATA;
`else
                            state_nxt_s = IGNORE;
`endif
                        end else if (DUMMY_CYCLES == 0) begin
                            mem_re_s    = 1'b1;
                            mem_addr_s  = addr_shift_s;
                            half_nxt_s  = 1'b0;
                            state_nxt_s = RDATA;
                        end else begin
                            state_nxt_s = DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (cnt_r == DUMMY_LAST) begin
                        cnt_nxt_s   = 8'd0;
                        mem_re_s    = 1'b1;
                        half_nxt_s  = 1'b0;
                        state_nxt_s = RDATA;
                    end else begin
                        cnt_nxt_s   = cnt_r + 8'd1;
                    end
                end
`ifdef QSPI_RESP_WRITE_EN
                WDATA: begin
                    if (!half_r) begin
                        wr_hi_nxt_s = data_s;
                        half_nxt_s  = 1'b1;
                    end else begin
                        mem_we_s    = 1'b1;
                        addr_nxt_s  = addr_inc_s;
                        half_nxt_s  = 1'b0;
                    end
                end
`endif
                RDATA, IGNORE: state_nxt_s = state_r;
                default:       state_nxt_s = IGNORE;
            endcase
        end else if (fall_s && state_r == RDATA) begin
            oe_nxt_s = 1'b1;
            if (!half_r) begin
                dout_nxt_s = rd_data_r[7:4];
                half_nxt_s = 1'b1;
            end else begin
                // Prefetch the next byte now; the RAM has a full SPI half-period to answer
                dout_nxt_s = rd_data_r[3:0];
                half_nxt_s = 1'b0;
                addr_nxt_s = addr_inc_s;
                mem_re_s   = 1'b1;
                mem_addr_s = addr_inc_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Control state and registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            addr_r   <= '0;
            cmd_hi_r <= 4'h0;
            rd_r     <= 1'b0;
            half_r   <= 1'b0;
            dout_r   <= 4'h0;
            oe_r     <= 1'b0;
            armed_r  <= 1'b0;
`ifdef QSPI_RESP_WRITE_EN
            wr_hi_r  <= 4'h0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            addr_r   <= addr_nxt_s;
            cmd_hi_r <= cmd_hi_nxt_s;
            rd_r     <= rd_nxt_s;
            half_r   <= half_nxt_s;
            dout_r   <= dout_nxt_s;
            oe_r     <= oe_nxt_s;
            armed_r  <= armed_r | cs_n_s;
`ifdef QSPI_RESP_WRITE_EN
            wr_hi_r  <= wr_hi_nxt_s;
`endif
        end
    end

    // Single-port RAM with registered read; contents survive rst_n
    always_ff @(posedge clk) begin
`ifdef QSPI_RESP_WRITE_EN
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= {wr_hi_r, data_s};
        end
`endif
        if (mem_re_s) begin
            rd_data_r <= mem_r[mem_addr_s];
        end
    end

    assign spi_data_o  = dout_r;
    assign spi_data_oe = {4{oe_r}};
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Randomised bench for qspi_mem_responder against a byte-array memory model.
module tb_qspi_mem_responder;
    localparam int ADDR_BITS    = 12;
    localparam int DUMMY_CYCLES = 4;
    localparam int DEPTH        = 1 << ADDR_BITS;
    localparam int HALF         = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk_i;
    logic       spi_cs_n_i;
    logic [3:0] spi_data_i;
    logic [3:0] spi_data_o;
    logic [3:0] spi_data_oe;

    int         checks   = 0;
    int         failures = 0;
    int         oe_seen;
    logic [7:0] model [DEPTH];
    logic [3:0] rd_nib [64];
    logic [3:0] rd_oe  [64];
    logic [3:0] post_oe;

    always #5 clk = ~clk;

    qspi_mem_responder #(.ADDR_BITS(ADDR_BITS), .DUMMY_CYCLES(DUMMY_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk_i(spi_clk_i), .spi_cs_n_i(spi_cs_n_i),
        .spi_data_i(spi_data_i), .spi_data_o(spi_data_o), .spi_data_oe(spi_data_oe)
    );

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    // One initiator-driven nibble: data set while SPI clock low, then high/low phase
    task automatic nib_cycle(input logic [3:0] n);
        spi_data_i = n;
        half_wait();
        if (spi_data_oe !== 4'h0) oe_seen++;
        spi_clk_i = 1'b1;
        half_wait();
        spi_clk_i = 1'b0;
    endtask

    task automatic cs_end();
        half_wait();
        spi_cs_n_i = 1'b1;
        repeat (3) @(negedge clk);
        post_oe = spi_data_oe;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_txn(input logic [23:0] addr, input int nnib);
        oe_seen    = 0;
        spi_cs_n_i = 1'b0;
        nib_cycle(4'h0);
        nib_cycle(4'hB);
        for (int i = 5; i >= 0; i--) nib_cycle(addr[i*4 +: 4]);
        for (int i = 0; i < DUMMY_CYCLES; i++) nib_cycle(4'($urandom_range(15)));
        spi_data_i = 4'h0;
        for (int i = 0; i < nnib; i++) begin
            half_wait();
            rd_nib[i] = spi_data_o;
            rd_oe[i]  = spi_data_oe;
            spi_clk_i = 1'b1;
            half_wait();
            spi_clk_i = 1'b0;
        end
        cs_end();
    endtask

    task automatic write_txn(input logic [23:0] addr, input logic [7:0] data [$], input bit trailing_half);
        oe_seen    = 0;
        spi_cs_n_i = 1'b0;
        nib_cycle(4'h0);
        nib_cycle(4'h2);
        for (int i = 5; i >= 0; i--) nib_cycle(addr[i*4 +: 4]);
        foreach (data[k]) begin
            nib_cycle(data[k][7:4]);
            nib_cycle(data[k][3:0]);
        end
        if (trailing_half) nib_cycle(4'($urandom_range(1, 15)));
        cs_end();
`ifdef QSPI_RESP_WRITE_EN
        foreach (data[k]) model[(int'(addr[ADDR_BITS-1:0]) + k) % DEPTH] = data[k];
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spi_cs_n_i = 1'b0; spi_clk_i = 1'b0; spi_data_i = 4'h0;
        for (int i = 0; i < 4; i++) nib_cycle(4'($urandom_range(15)));
        checks++;
        if (spi_data_oe !== 4'h0) begin failures++; $display("FAIL reset_oe: got %h expected 0", spi_data_oe); end
        checks++;
        if (spi_data_o !== 4'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", spi_data_o); end
        @(negedge clk);
        rst_n   = 1'b1;
        oe_seen = 0;
        nib_cycle(4'h0); nib_cycle(4'hB);
        for (int i = 0; i < 6 + DUMMY_CYCLES + 6; i++) nib_cycle(4'h0);
        cs_end();
        checks++;
        if (oe_seen !== 0) begin failures++; $display("FAIL reset_no_response: oe seen %0d times, expected 0", oe_seen); end
    endtask

    task automatic test_reset_abort();
        logic [3:0] n0, o0;
        logic [7:0] b;
        oe_seen = 0; spi_cs_n_i = 1'b0;
        nib_cycle(4'h0); nib_cycle(4'hB);
        for (int i = 0; i < 6; i++) nib_cycle(i == 4 ? 4'h1 : 4'h0);
        for (int i = 0; i < DUMMY_CYCLES; i++) nib_cycle(4'h0);
        half_wait();
        n0 = spi_data_o; o0 = spi_data_oe;
        spi_clk_i = 1'b1; half_wait(); spi_clk_i = 1'b0;
        b = model[16];
        checks++;
        if (n0 !== b[7:4] || o0 !== 4'hF) begin failures++; $display("FAIL abort_first_nib: got %h/%h expected %h/f", n0, o0, b[7:4]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (spi_data_oe !== 4'h0 || spi_data_o !== 4'h0) begin failures++; $display("FAIL abort_in_reset: got %h/%h expected 0/0", spi_data_o, spi_data_oe); end
        rst_n = 1'b1; oe_seen = 0;
        for (int i = 0; i < 10; i++) nib_cycle(4'($urandom_range(15)));
        cs_end();
        checks++;
        if (oe_seen !== 0) begin failures++; $display("FAIL abort_after_release: oe seen %0d times, expected 0", oe_seen); end
    endtask

    task automatic test_write_read();
        logic [7:0] q [$];
        logic [7:0] b;
        logic [3:0] e;
        q.push_back(8'hA5); q.push_back(8'h3C);
        write_txn(24'h000010, q, 1'b0);
        read_txn(24'h000010, 4);
        checks++;
        if (oe_seen !== 0) begin failures++; $display("FAIL wr_rd_early_oe: oe seen %0d times, expected 0", oe_seen); end
        for (int i = 0; i < 4; i++) begin
            b = model[16 + i/2];
            e = (i % 2 == 0) ? b[7:4] : b[3:0];
            checks++;
            if (rd_nib[i] !== e || rd_oe[i] !== 4'hF) begin failures++; $display("FAIL wr_rd_nib%0d: got %h/%h expected %h/f", i, rd_nib[i], rd_oe[i], e); end
        end
        checks++;
        if (post_oe !== 4'h0) begin failures++; $display("FAIL wr_rd_oe_release: got %h expected 0", post_oe); end
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] b;
        logic [3:0] e;
        q.push_back(8'h11); write_txn(24'h000FFF, q, 1'b0);
        q.delete(); q.push_back(8'h22); write_txn(24'h000000, q, 1'b0);
        read_txn(24'h000FFF, 4);
        for (int i = 0; i < 4; i++) begin
            b = model[(DEPTH - 1 + i/2) % DEPTH];
            e = (i % 2 == 0) ? b[7:4] : b[3:0];
            checks++;
            if (rd_nib[i] !== e) begin failures++; $display("FAIL wrap_nib%0d: got %h expected %h", i, rd_nib[i], e); end
        end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] b;
        oe_seen = 0; spi_cs_n_i = 1'b0;
        nib_cycle(4'h9); nib_cycle(4'hF);
        for (int i = 0; i < 16; i++) nib_cycle(i < 6 ? (i == 4 ? 4'h4 : 4'h0) : 4'h7);
        cs_end();
        checks++;
        if (oe_seen !== 0 || post_oe !== 4'h0) begin failures++; $display("FAIL unknown_oe: oe seen %0d times, expected 0", oe_seen); end
        read_txn(24'h000040, 2);
        b = model[64];
        checks++;
        if ({rd_nib[0], rd_nib[1]} !== b) begin failures++; $display("FAIL unknown_mem: got %h expected %h", {rd_nib[0], rd_nib[1]}, b); end
    endtask

    task automatic test_cs_abort();
        logic [7:0] q [$];
        logic [7:0] b;
        write_txn(24'h000020, q, 1'b1);
        checks++;
        if (post_oe !== 4'h0) begin failures++; $display("FAIL cs_abort_wr_oe: got %h expected 0", post_oe); end
        read_txn(24'h000020, 1);
        checks++;
        if (rd_oe[0] !== 4'hF || post_oe !== 4'h0) begin failures++; $display("FAIL cs_abort_rd_oe: got %h then %h expected f then 0", rd_oe[0], post_oe); end
        read_txn(24'h000020, 4);
        for (int i = 0; i < 2; i++) begin
            b = model[32 + i];
            checks++;
            if ({rd_nib[2*i], rd_nib[2*i+1]} !== b) begin failures++; $display("FAIL cs_abort_mem%0d: got %h expected %h", i, {rd_nib[2*i], rd_nib[2*i+1]}, b); end
        end
    endtask

    task automatic test_write_protect();
        logic [7:0] q [$];
        logic [7:0] b;
        q.push_back(8'hFF);
        write_txn(24'h000000, q, 1'b0);
        read_txn(24'h000000, 2);
        b = model[0];
        checks++;
        if ({rd_nib[0], rd_nib[1]} !== b) begin failures++; $display("FAIL write_protect: got %h expected %h", {rd_nib[0], rd_nib[1]}, b); end
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [7:0]  q [$];
        logic [7:0]  b;
        logic [3:0]  e;
        int          n;
        for (int t = 0; t < 24; t++) begin
            a = 24'($urandom);
            if (t % 5 == 0) a[ADDR_BITS-1:0] = ADDR_BITS'(DEPTH - 1 - $urandom_range(1));
            n = $urandom_range(1, 4);
            if ($urandom_range(1) == 1) begin
                q.delete();
                for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                write_txn(a, q, 1'($urandom_range(1)));
            end else begin
                read_txn(a, 2 * n);
                for (int i = 0; i < 2 * n; i++) begin
                    b = model[(int'(a[ADDR_BITS-1:0]) + i/2) % DEPTH];
                    e = (i % 2 == 0) ? b[7:4] : b[3:0];
                    checks++;
                    if (rd_nib[i] !== e || rd_oe[i] !== 4'hF) begin failures++; $display("FAIL random_t%0d_nib%0d: got %h/%h expected %h/f", t, i, rd_nib[i], rd_oe[i], e); end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; spi_cs_n_i = 1'b0; spi_clk_i = 1'b0; spi_data_i = 4'h0;
`ifdef QSPI_RESP_WRITE_EN
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`else
        for (int i = 0; i < DEPTH; i++) model[i] = 8'($urandom);
        model[0] = 8'h5A; model[32] = 8'h96; model[64] = 8'hC3;
        #1;
        for (int i = 0; i < DEPTH; i++) dut.mem_r[i] = model[i];
`endif
        test_reset();
        test_write_read();
        test_reset_abort();
        test_wrap();
        test_unknown_cmd();
        test_cs_abort();
        test_write_protect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
